paddle_move_ctrl: RTL and testbench

PADDLE_MOVE_CTRL -- requirements
Module: paddle_move_ctrl

---
 rtl/paddle_move_ctrl_if.sv | 24 ++
 rtl/paddle_move_ctrl.sv | 139 +++++++++++++
 tb/tb_paddle_move_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_move_ctrl_if.sv
// Paddle motion bundle: raw frame sync, buttons and auto-track geometry in; motion command out.
// The master drives the raw inputs and observes the command; the slave is the controller.
interface paddle_move_ctrl_if;
    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       auto_en;
    logic [9:0] ball_x;
    logic [9:0] paddle_center;
    logic       left;
    logic       right;
    logic [1:0] speed;
    logic       src_auto;

    modport master (
        output vsync, btn_left, btn_right, auto_en, ball_x, paddle_center,
        input  left, right, speed, src_auto
    );

    modport slave (
        input  vsync, btn_left, btn_right, auto_en, ball_x, paddle_center,
        output left, right, speed, src_auto
    );
endinterface

// File: rtl/paddle_move_ctrl.sv
// Paddle move controller: debounced player buttons override an auto-tracker, speed ramps per frame.
// Latency: command registers update one clk after the synchronized vsync rising edge.
// Backpressure: none; the command is held for the whole frame and the datapath must accept it.
module paddle_move_ctrl #(
    parameter int DEBOUNCE_CYCLES = 15000,
    parameter int RAMP_FRAMES     = 8,
    parameter int MAX_SPEED       = 3,
    parameter int DEADZONE        = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    paddle_move_ctrl_if.slave  io
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int              FC_W    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(RAMP_FRAMES - 1);
    localparam logic [1:0]      SPD_MAX = 2'(MAX_SPEED);
    localparam logic [10:0]     DZ      = 11'(DEADZONE);

    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_e;
    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} state_e;

    // vsync synchronizer plus one extra stage for rising-edge detection
    logic vs_s1, vs_s2, vs_d;
    logic frame_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            vs_s1 <= io.vsync;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign frame_tick = vs_s2 & ~vs_d;

    // bit 0 = left, bit 1 = right
    logic [1:0]      btn_raw;
    logic [1:0]      btn_deb;
    logic [DB_W-1:0] db_cnt [2];

    assign btn_raw = {io.btn_right, io.btn_left};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_deb <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_raw[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]  <= '0;
                    btn_deb[i] <= btn_raw[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    dir_e ply_dir, auto_dir, req_dir, cur_dir;
    logic req_auto;

    // 11-bit sums keep the deadzone compare free of wrap at both screen edges
    always_comb begin
        ply_dir  = DIR_NONE;
        auto_dir = DIR_NONE;
        if (btn_deb == 2'b01) ply_dir = DIR_L;
        else if (btn_deb == 2'b10) ply_dir = DIR_R;
        if (io.auto_en) begin
            if (({1'b0, io.ball_x} + DZ) < {1'b0, io.paddle_center})
                auto_dir = DIR_L;
            else if ({1'b0, io.ball_x} > ({1'b0, io.paddle_center} + DZ))
                auto_dir = DIR_R;
        end
        req_dir  = (ply_dir != DIR_NONE) ? ply_dir : auto_dir;
        req_auto = (ply_dir == DIR_NONE) && (auto_dir != DIR_NONE);
    end

    state_e          state;
    logic [FC_W-1:0] frame_cnt;
    logic            left_q, right_q, src_auto_q;
    logic [1:0]      speed_q;

    assign cur_dir = left_q ? DIR_L : (right_q ? DIR_R : DIR_NONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            speed_q    <= 2'd0;
            src_auto_q <= 1'b0;
        end else if (frame_tick) begin
            if (req_dir == DIR_NONE) begin
                state      <= IDLE;
                frame_cnt  <= '0;
                left_q     <= 1'b0;
                right_q    <= 1'b0;
                speed_q    <= 2'd0;
                src_auto_q <= 1'b0;
            end else begin
                src_auto_q <= req_auto;
                if (state == IDLE || req_dir != cur_dir) begin
                    // fresh start or reversal: restart the ramp from speed 1
                    left_q    <= (req_dir == DIR_L);
                    right_q   <= (req_dir == DIR_R);
                    speed_q   <= 2'd1;
                    frame_cnt <= '0;
                    state     <= (SPD_MAX == 2'd1) ? CRUISE : RAMP;
                end else if (state == RAMP) begin
                    if (frame_cnt == FC_LAST) begin
                        speed_q   <= speed_q + 2'd1;
                        frame_cnt <= '0;
                        if (speed_q + 2'd1 == SPD_MAX) state <= CRUISE;
                    end else begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end else begin
                    speed_q <= SPD_MAX;
                end
            end
        end
    end

    assign io.left     = left_q;
    assign io.right    = right_q;
    assign io.speed    = speed_q;
    assign io.src_auto = src_auto_q;

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Bench for paddle_move_ctrl: frame-level behavioural model compared every cycle, plus directed literal checks.
module tb_paddle_move_ctrl;
    localparam int DB = 4;
    localparam int RF = 2;
    localparam int MS = 3;
    localparam int DZ = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    paddle_move_ctrl_if io ();

    paddle_move_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .RAMP_FRAMES     (RF),
        .MAX_SPEED       (MS),
        .DEADZONE        (DZ)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clk = ~clk;

    // Model: direction held plus number of frames spent in it; speed follows from that count.
    bit       m_deb [2];
    int       m_cnt [2];
    bit [2:0] m_vs;
    int       m_dir  = 0;  // 0 none, 1 left, 2 right
    int       m_h    = 0;
    bit       m_auto = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_deb[0] = 0; m_deb[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
            m_vs = '0; m_dir = 0; m_h = 0; m_auto = 0;
        end else begin
            int pr, ar, req;
            bit raw [2];
            if (m_vs[1] && !m_vs[2]) begin
                pr = (m_deb[0] && !m_deb[1]) ? 1 : (m_deb[1] && !m_deb[0]) ? 2 : 0;
                ar = 0;
                if (io.auto_en) begin
                    if (int'(io.ball_x) + DZ < int'(io.paddle_center)) ar = 1;
                    else if (int'(io.ball_x) > int'(io.paddle_center) + DZ) ar = 2;
                end
                req = (pr != 0) ? pr : ar;
                if (req == 0) begin
                    m_dir = 0; m_h = 0; m_auto = 0;
                end else begin
                    m_auto = (pr == 0);
                    if (req == m_dir) m_h = m_h + 1;
                    else begin m_dir = req; m_h = 0; end
                end
            end
            raw[0] = io.btn_left;
            raw[1] = io.btn_right;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == m_deb[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == DB) begin m_deb[i] = raw[i]; m_cnt[i] = 0; end
                end
            end
            m_vs = {m_vs[1:0], io.vsync};
        end
    end

    function automatic int exp_speed();
        int s;
        if (m_dir == 0) return 0;
        s = 1 + m_h / RF;
        return (s > MS) ? MS : s;
    endfunction

    always @(negedge clk) begin
        checks++;
        if (io.left !== (m_dir == 1) || io.right !== (m_dir == 2) ||
            int'(io.speed) != exp_speed() || io.src_auto !== m_auto) begin
            errors++;
            $display("FAIL model t=%0t: got l=%0b r=%0b speed=%0d auto=%0b, want l=%0b r=%0b speed=%0d auto=%0b",
                     $time, io.left, io.right, io.speed, io.src_auto,
                     (m_dir == 1), (m_dir == 2), exp_speed(), m_auto);
        end
        checks++;
        if ((io.left && io.right) || ((io.speed != 2'd0) != (io.left || io.right))) begin
            errors++;
            $display("FAIL invariant t=%0t: got l=%0b r=%0b speed=%0d, want exclusive dir and speed!=0 iff moving",
                     $time, io.left, io.right, io.speed);
        end
    end

    task automatic check_lit(input string name, input bit l, input bit r,
                             input logic [1:0] s, input bit a);
        checks++;
        if (io.left !== l || io.right !== r || io.speed !== s || io.src_auto !== a) begin
            errors++;
            $display("FAIL %s: got l=%0b r=%0b speed=%0d auto=%0b, want l=%0b r=%0b speed=%0d auto=%0b",
                     name, io.left, io.right, io.speed, io.src_auto, l, r, s, a);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        wait_clks(6);
    endtask

    task automatic frame();
        @(negedge clk);
        io.vsync = 1'b1;
        wait_clks(2);
        io.vsync = 1'b0;
        wait_clks(4);
    endtask

    logic [1:0] ramp_spd [6];

    initial begin
        ramp_spd = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        io.vsync = 0; io.btn_left = 0; io.btn_right = 0; io.auto_en = 0;
        io.ball_x = '0; io.paddle_center = '0;

        wait_clks(3);
        check_lit("reset", 0, 0, 2'd0, 0);
        reset_n = 1'b1;
        wait_clks(2);
        check_lit("idle_after_reset", 0, 0, 2'd0, 0);

        // debounced press alone must not issue a command before a frame
        io.btn_left = 1;
        settle();
        check_lit("no_frame_no_cmd", 0, 0, 2'd0, 0);
        io.btn_left = 0;
        settle();

        // 3-cycle glitch rejected
        @(negedge clk);
        io.btn_left = 1;
        wait_clks(3);
        io.btn_left = 0;
        wait_clks(2);
        frame();
        check_lit("glitch", 0, 0, 2'd0, 0);

        io.btn_right = 1;
        settle();
        for (int k = 0; k < 6; k++) begin
            frame();
            check_lit($sformatf("ramp_f%0d", k), 0, 1, ramp_spd[k], 0);
        end

        io.btn_right = 0; io.btn_left = 1;
        settle();
        frame();
        check_lit("reverse", 1, 0, 2'd1, 0);
        io.btn_left = 0;
        settle();
        frame();
        check_lit("release", 0, 0, 2'd0, 0);

        io.auto_en = 1; io.ball_x = 10'd100; io.paddle_center = 10'd200;
        frame();
        check_lit("auto_left", 1, 0, 2'd1, 1);
        io.btn_right = 1;
        settle();
        frame();
        check_lit("player_override", 0, 1, 2'd1, 0);
        io.btn_right = 0; io.ball_x = 10'd205;
        settle();
        frame();
        check_lit("auto_deadzone", 0, 0, 2'd0, 0);

        // source swaps keep the ramp position
        io.ball_x = 10'd300;
        frame();
        check_lit("auto_right", 0, 1, 2'd1, 1);
        io.btn_right = 1;
        settle();
        frame();
        check_lit("src_to_player", 0, 1, 2'd1, 0);
        frame();
        check_lit("player_ramp", 0, 1, 2'd2, 0);
        io.btn_right = 0;
        settle();
        frame();
        check_lit("src_to_auto", 0, 1, 2'd2, 1);
        io.ball_x = 10'd205;
        frame();
        check_lit("auto_stop", 0, 0, 2'd0, 0);

        io.auto_en = 0; io.btn_left = 1; io.btn_right = 1;
        settle();
        frame();
        check_lit("both_buttons", 0, 0, 2'd0, 0);
        io.btn_left = 0; io.btn_right = 0;
        settle();
        io.auto_en = 1; io.ball_x = 10'd0; io.paddle_center = 10'd5;
        frame();
        check_lit("low_edge", 0, 0, 2'd0, 0);
        io.ball_x = 10'd1023; io.paddle_center = 10'd1015;
        frame();
        check_lit("high_edge", 0, 0, 2'd0, 0);
        io.paddle_center = 10'd1014;
        frame();
        check_lit("high_edge_r", 0, 1, 2'd1, 1);
        io.ball_x = 10'd0; io.paddle_center = 10'd9;
        frame();
        check_lit("low_edge_l", 1, 0, 2'd1, 1);
        io.auto_en = 0;
        frame();
        check_lit("auto_off", 0, 0, 2'd0, 0);

        io.btn_right = 1;
        settle();
        frame(); frame(); frame();
        check_lit("pre_reset", 0, 1, 2'd2, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_lit("async_reset", 0, 0, 2'd0, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        wait_clks(1);
        check_lit("after_release", 0, 0, 2'd0, 0);
        settle();
        frame();
        check_lit("resume", 0, 1, 2'd1, 0);
        io.btn_right = 0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
